// File: rtl/credit_sender.sv
// credit_sender: ready/valid to credit-link transmitter with saturating credit counter.
// Optional sticky overflow detection: CREDIT_SENDER_OVERFLOW_CHECK_EN. Rev 1.0
`default_nettype none

module credit_sender #(
  parameter int Width       = 8,
  parameter int MaxCredits  = 4,
  parameter int CreditWidth = $clog2(MaxCredits + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [Width-1:0]       data_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [Width-1:0]       data_o,
  input  logic                   credit_i,
  output logic [CreditWidth-1:0] credits_o,
  output logic                   idle_o,
  output logic                   err_o
);

  localparam logic [CreditWidth-1:0] MaxCreditsC = CreditWidth'(MaxCredits);
  localparam logic [CreditWidth-1:0] OneC        = CreditWidth'(1);

  logic [CreditWidth-1:0] credits_d, credits_q;
  logic                   valid_d, valid_q;
  logic [Width-1:0]       data_d, data_q;
  logic                   send;

  assign ready_o = (credits_q != '0);
  assign send    = valid_i & ready_o;

  always_comb begin
    credits_d = credits_q;
    valid_d   = send;
    data_d    = data_q;
    if (send) begin
      data_d = data_i;
    end
    // A credit with no send at full count saturates instead of wrapping.
    if (send && !credit_i) begin
      credits_d = credits_q - OneC;
    end else if (!send && credit_i && (credits_q != MaxCreditsC)) begin
      credits_d = credits_q + OneC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q <= MaxCreditsC;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      credits_q <= credits_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  assign credits_o = credits_q;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign idle_o    = (credits_q == MaxCreditsC) & ~valid_q;

`ifdef CREDIT_SENDER_OVERFLOW_CHECK_EN
  logic overflow;
  logic err_d, err_q;

  assign overflow = credit_i & ~send & (credits_q == MaxCreditsC);

  always_comb begin
    err_d = err_q | overflow;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_credit_sender.sv
// Directed self-checking bench for credit_sender (Width=8, MaxCredits=4).
`default_nettype none

module tb_credit_sender;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       credit_i = 1'b0;
  logic [2:0] credits_o;
  logic       idle_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;
  logic exp_err;

  credit_sender #(.Width(8), .MaxCredits(4)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .credit_i  (credit_i),
    .credits_o (credits_o),
    .idle_o    (idle_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] cr, input logic rdy,
                         input logic vld, input logic [7:0] dat, input logic idl);
    chk({tag, "_credits"}, 32'(credits_o), 32'(cr));
    chk({tag, "_ready"},   32'(ready_o),   32'(rdy));
    chk({tag, "_valid"},   32'(valid_o),   32'(vld));
    chk({tag, "_data"},    32'(data_o),    32'(dat));
    chk({tag, "_idle"},    32'(idle_o),    32'(idl));
  endtask

  initial begin
`ifdef CREDIT_SENDER_OVERFLOW_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Reset held across edges
    #12;
    chk_out("rst_hold", 3'd4, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("rst_hold_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;
    step();
    chk_out("post_rst", 3'd4, 1'b1, 1'b0, 8'h00, 1'b1);

    // Burst to exhaustion
    valid_i = 1'b1; data_i = 8'h11;
    step(); chk_out("burst1", 3'd3, 1'b1, 1'b1, 8'h11, 1'b0); data_i = 8'h12;
    step(); chk_out("burst2", 3'd2, 1'b1, 1'b1, 8'h12, 1'b0); data_i = 8'h13;
    step(); chk_out("burst3", 3'd1, 1'b1, 1'b1, 8'h13, 1'b0); data_i = 8'h14;
    step(); chk_out("burst4", 3'd0, 1'b0, 1'b1, 8'h14, 1'b0); data_i = 8'h15;
    step(); chk_out("stall1", 3'd0, 1'b0, 1'b0, 8'h14, 1'b0);
    step(); chk_out("stall2", 3'd0, 1'b0, 1'b0, 8'h14, 1'b0);

    // Recovery from zero credits
    credit_i = 1'b1;
    step(); chk_out("recov_n1", 3'd1, 1'b1, 1'b0, 8'h14, 1'b0);
    credit_i = 1'b0;
    step(); chk_out("recov_n2", 3'd0, 1'b0, 1'b1, 8'h15, 1'b0);
    valid_i = 1'b0;

    // Simultaneous send and credit at 2 credits
    credit_i = 1'b1;
    step(); chk_out("refill1", 3'd1, 1'b1, 1'b0, 8'h15, 1'b0);
    step(); chk_out("refill2", 3'd2, 1'b1, 1'b0, 8'h15, 1'b0);
    valid_i = 1'b1; data_i = 8'hA5;
    step(); chk_out("simul", 3'd2, 1'b1, 1'b1, 8'hA5, 1'b0);
    valid_i = 1'b0;

    // Refill to full, then saturating credit return
    step(); chk_out("full3", 3'd3, 1'b1, 1'b0, 8'hA5, 1'b0);
    step(); chk_out("full4", 3'd4, 1'b1, 1'b0, 8'hA5, 1'b1);
    chk("pre_ovf_err", 32'(err_o), 32'd0);
    step(); chk_out("ovf", 3'd4, 1'b1, 1'b0, 8'hA5, 1'b1);
    chk("ovf_err", 32'(err_o), 32'(exp_err));
    credit_i = 1'b0;
    step(); chk("ovf_err_sticky", 32'(err_o), 32'(exp_err));
    chk("ovf_credits_hold", 32'(credits_o), 32'd4);

    // Three sends to reach credits=1 with valid_o high, then async reset
    valid_i = 1'b1; data_i = 8'h31;
    step(); data_i = 8'h32;
    step(); data_i = 8'h33;
    step(); chk_out("pre_arst", 3'd1, 1'b1, 1'b1, 8'h33, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_out("arst", 3'd4, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("arst_err", 32'(err_o), 32'd0);
    valid_i = 1'b0;
    step(); chk_out("arst_hold", 3'd4, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
